axi_frame_stream_tx: RTL and testbench

- AXI-Stream master that packs one image frame into 256-bit pixel-group beats (32 x 8-bit pixels) and sends it to the image-processor slave port.
- It is the transmit end of the frame stream that the image processor consumes.
- Pixel groups arrive in raster order from the sensor/frame-buffer side over a valid/ready interface.
- The block buffers them in a small FIFO and emits exactly one AXI-Stream packet per frame, with tlast on the final pixel group.
- The frame tid is stamped per frame and tdest is latched at frame start.

---
 rtl/axi_frame_stream_tx_pkg.sv | 32 +++
 rtl/axi_frame_stream_tx_if.sv | 32 +++
 rtl/axis_tx_fifo.sv | 88 ++++++++
 rtl/axi_frame_stream_tx.sv | 129 ++++++++++++
 tb/tb_axi_frame_stream_tx.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_frame_stream_tx_pkg.sv
// Shared definitions for the frame-stream transmit path.
// Holds the pixel-group geometry, the default AXI-Stream widths, the
// transmit FSM state encoding and the width-derivation helpers used by the
// interface, the top level and the frame-fetch side of the codebase.
package axi_frame_stream_tx_pkg;

  // One pixel group is 32 pixels of 8 bits each, so one beat is 256 bits.
  localparam int PIXEL_W         = 8;
  localparam int PG_PIXELS       = 32;
  localparam int DEF_IP_DATA_W   = PIXEL_W * PG_PIXELS;
  // A 320x240 frame split into 32-pixel groups.
  localparam int DEF_FRAME_PGNUM = (320 * 240) / PG_PIXELS;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TID_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } tx_state_e;

  // tdest needs at least one bit even with a single image processor.
  function automatic int axis_tdest_w(input int ip_addr_w);
    return (ip_addr_w > 1) ? ip_addr_w : 1;
  endfunction

  // Byte-lane count for tkeep/tstrb.
  function automatic int axis_byte_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi_frame_stream_tx_if.sv
// AXI-Stream bundle carrying pixel-group beats to an image processor.
// Signals: tid (frame id), tdest (destination processor), tdata (beat),
// tkeep/tstrb (byte qualifiers), tlast (final beat of frame), tvalid/tready
// (handshake). The master drives everything except tready.
interface axi_frame_stream_tx_if
  import axi_frame_stream_tx_pkg::*;
#(
  parameter int TID_W   = DEF_TID_W,
  parameter int TDEST_W = 1,
  parameter int TDATA_W = DEF_IP_DATA_W
) ();

  logic [TID_W-1:0]              tid;
  logic [TDEST_W-1:0]            tdest;
  logic [TDATA_W-1:0]            tdata;
  logic [axis_byte_w(TDATA_W)-1:0] tkeep;
  logic [axis_byte_w(TDATA_W)-1:0] tstrb;
  logic                          tlast;
  logic                          tvalid;
  logic                          tready;

  modport master (
    output tid, tdest, tdata, tkeep, tstrb, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tid, tdest, tdata, tkeep, tstrb, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/axis_tx_fifo.sv
// First-word fall-through FIFO buffering outgoing beats.
// Ports: clk/rst (async active-high), push_i/push_data_i (write side),
// pop_i (read acknowledge), head_data_o (oldest entry, valid when !empty_o),
// full_o/empty_o (registered occupancy flags).
// Flags are registered so a write becomes visible at the head one cycle after
// it is pushed, and the writer can gate on full without a combinational path
// from the reader.
module axis_tx_fifo
  import axi_frame_stream_tx_pkg::*;
#(
  parameter int WIDTH = DEF_IP_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_s;
  logic             pop_s;

  // A write into a full FIFO is dropped even if a pop happens the same cycle.
  assign push_s = push_i && !full_r;
  assign pop_s  = pop_i && !empty_r;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  assign head_data_o = mem_r[rd_ptr_r];
  assign full_o      = full_r;
  assign empty_o     = empty_r;

endmodule

// File: rtl/axi_frame_stream_tx.sv
// AXI-Stream master sending one image frame per start pulse.
// Ports: clk, rst (async active-high); start_i/dest_i begin a frame and pick
// its destination; pg_data_i/pg_valid_i/pg_ready_o accept raster-order pixel
// groups; m_axis carries the packet (one beat per pixel group, tlast on the
// last one); busy_o flags a frame in progress; frame_done_o pulses for one
// cycle after the tlast beat has been accepted downstream.
module axi_frame_stream_tx
  import axi_frame_stream_tx_pkg::*;
#(
  parameter int IP_AMT       = 1,
  parameter int IP_ADDR_W    = $clog2(IP_AMT),
  parameter int IP_DATA_W    = DEF_IP_DATA_W,
  parameter int AXIS_TID_W   = DEF_TID_W,
  parameter int AXIS_TDEST_W = axis_tdest_w(IP_ADDR_W),
  parameter int AXIS_TDATA_W = IP_DATA_W,
  parameter int AXIS_TKEEP_W = AXIS_TDATA_W / 8,
  parameter int AXIS_TSTRB_W = AXIS_TDATA_W / 8,
  parameter int FRAME_PGNUM  = DEF_FRAME_PGNUM,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [AXIS_TDEST_W-1:0] dest_i,
  input  logic [IP_DATA_W-1:0]    pg_data_i,
  input  logic                    pg_valid_i,
  output logic                    pg_ready_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  axi_frame_stream_tx_if.master   m_axis
);

  localparam int CNT_W   = $clog2(FRAME_PGNUM + 1);
  localparam int ENTRY_W = IP_DATA_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(FRAME_PGNUM - 1);

  tx_state_e                state_r;
  logic [CNT_W-1:0]         pg_cnt_r;
  logic [AXIS_TID_W-1:0]    tid_r;
  logic [AXIS_TDEST_W-1:0]  tdest_r;
  logic                     frame_done_r;

  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic                     pg_ready_s;
  logic                     pg_accept_s;
  logic                     pg_last_s;
  logic                     beat_pop_s;
  logic                     last_hs_s;
  logic [ENTRY_W-1:0]       push_entry_s;
  logic [ENTRY_W-1:0]       head_entry_s;

  // Pixel groups are taken only while streaming and the buffer has room.
  assign pg_ready_s   = (state_r == ST_STREAM) && !fifo_full_s;
  assign pg_accept_s  = pg_valid_i && pg_ready_s;
  assign pg_last_s    = (pg_cnt_r == LAST_IDX_C);
  // Each entry carries its own last flag in the top bit.
  assign push_entry_s = {pg_last_s, pg_data_i};
  assign beat_pop_s   = !fifo_empty_s && m_axis.tready;
  assign last_hs_s    = beat_pop_s && head_entry_s[IP_DATA_W];

  axis_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pg_accept_s),
    .push_data_i (push_entry_s),
    .pop_i       (beat_pop_s),
    .head_data_o (head_entry_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Frame sequencing: destination latch, group count, frame id and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pg_cnt_r     <= {CNT_W{1'b0}};
      tid_r        <= {AXIS_TID_W{1'b0}};
      tdest_r      <= {AXIS_TDEST_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_r  <= ST_STREAM;
            tdest_r  <= dest_i;
            pg_cnt_r <= {CNT_W{1'b0}};
          end
        end
        ST_STREAM: begin
          // start_i is deliberately not looked at once a frame is running.
          if (pg_accept_s) begin
            pg_cnt_r <= pg_cnt_r + CNT_W'(1);
            if (pg_last_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_hs_s) begin
            state_r      <= ST_IDLE;
            tid_r        <= tid_r + AXIS_TID_W'(1);
            frame_done_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign pg_ready_o    = pg_ready_s;
  assign busy_o        = (state_r != ST_IDLE);
  assign frame_done_o  = frame_done_r;

  assign m_axis.tvalid = !fifo_empty_s;
  assign m_axis.tdata  = head_entry_s[AXIS_TDATA_W-1:0];
  assign m_axis.tlast  = head_entry_s[IP_DATA_W];
  assign m_axis.tid    = tid_r;
  assign m_axis.tdest  = tdest_r;
  assign m_axis.tkeep  = {AXIS_TKEEP_W{1'b1}};
  assign m_axis.tstrb  = {AXIS_TSTRB_W{1'b1}};

endmodule

// File: tb/tb_axi_frame_stream_tx.sv
// Bench for axi_frame_stream_tx: a 4-group-frame instance driven with random
// and directed traffic and checked by a queue-based frame model, plus a
// 1-group-frame instance exercised with a short directed sequence.
module tb_axi_frame_stream_tx;

  localparam int DW    = 256;
  localparam int TIDW  = 2;
  localparam int DSTW  = 1;
  localparam int PGNUM = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic            last;
    logic [TIDW-1:0] tid;
    logic [DSTW-1:0] dest;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic [DSTW-1:0] dest_i;
  logic [DW-1:0]   pg_data_i;
  logic            pg_valid_i;
  logic            pg_ready_o;
  logic            busy_o;
  logic            frame_done_o;

  logic            d1_start;
  logic [DSTW-1:0] d1_dest;
  logic [DW-1:0]   d1_data;
  logic            d1_valid;
  logic            d1_ready;
  logic            d1_busy;
  logic            d1_done;

  int n_vec = 0;
  int n_err = 0;

  axi_frame_stream_tx_if #(.TID_W(TIDW), .TDEST_W(DSTW), .TDATA_W(DW)) m_axis ();
  axi_frame_stream_tx_if #(.TID_W(TIDW), .TDEST_W(DSTW), .TDATA_W(DW)) s_axis1 ();

  axi_frame_stream_tx #(.AXIS_TID_W(TIDW), .FRAME_PGNUM(PGNUM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .dest_i(dest_i),
    .pg_data_i(pg_data_i), .pg_valid_i(pg_valid_i), .pg_ready_o(pg_ready_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .m_axis(m_axis)
  );

  axi_frame_stream_tx #(.AXIS_TID_W(TIDW), .FRAME_PGNUM(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .start_i(d1_start), .dest_i(d1_dest),
    .pg_data_i(d1_data), .pg_valid_i(d1_valid), .pg_ready_o(d1_ready),
    .busy_o(d1_busy), .frame_done_o(d1_done), .m_axis(s_axis1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_pg();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model + monitor (dut) ----------------
  // Frame-level model: a queue of beats pushed but not yet sent, the number
  // of groups taken in the current frame, and the running frame id.
  beat_t           exp_q[$];
  int              m_phase = 0;   // 0 idle, 1 collecting groups, 2 waiting for last beat
  int              m_cnt = 0;
  logic [TIDW-1:0] m_tid = '0;
  logic [DSTW-1:0] m_dest = '0;
  logic            m_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_phase = 0;
        m_cnt   = 0;
        m_tid   = '0;
        m_dest  = '0;
        m_done  = 1'b0;
      end else begin
        logic  exp_ready;
        int    pre;
        beat_t b;
        exp_ready = (m_phase == 1) && (exp_q.size() < DEPTH);
        chk("pg_ready", 260'(pg_ready_o), 260'(exp_ready));
        chk("busy", 260'(busy_o), 260'(m_phase != 0));
        chk("frame_done", 260'(frame_done_o), 260'(m_done));
        chk("tvalid", 260'(m_axis.tvalid), 260'(exp_q.size() != 0));
        if (m_axis.tvalid && exp_q.size() != 0) begin
          chk("tdata", 260'(m_axis.tdata), 260'(exp_q[0].data));
          chk("tlast", 260'(m_axis.tlast), 260'(exp_q[0].last));
          chk("tid", 260'(m_axis.tid), 260'(exp_q[0].tid));
          chk("tdest", 260'(m_axis.tdest), 260'(exp_q[0].dest));
          chk("tkeep_tstrb", 260'({m_axis.tkeep, m_axis.tstrb}), 260'({64{1'b1}}));
        end
        // advance the model across the coming clock edge
        pre    = m_phase;
        m_done = 1'b0;
        if (m_axis.tvalid && m_axis.tready && exp_q.size() != 0) begin
          b = exp_q.pop_front();
          if (b.last) begin
            m_phase = 0;
            m_tid   = m_tid + 1'b1;
            m_done  = 1'b1;
          end
        end
        if (pre == 1 && pg_valid_i && exp_ready) begin
          b.data = pg_data_i;
          b.last = (m_cnt == PGNUM - 1);
          b.tid  = m_tid;
          b.dest = m_dest;
          exp_q.push_back(b);
          m_cnt++;
          if (m_cnt == PGNUM) m_phase = 2;
        end
        if (pre == 0 && start_i) begin
          m_phase = 1;
          m_cnt   = 0;
          m_dest  = dest_i;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // vmode: 0 always valid, 1 valid on alternate cycles, 2 random
  // rmode: 0 always ready, 1 stalled for 12 cycles then ready, 2 random
  task automatic run_frame(input int vmode, input int rmode, input bit inj_start, input bit directed);
    bit done = 1'b0;
    int dcyc = -1;
    start_i    = 1'b1;
    dest_i     = DSTW'($urandom);
    pg_valid_i = 1'b0;
    cycle();
    start_i = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      case (vmode)
        0:       pg_valid_i = 1'b1;
        1:       pg_valid_i = (c % 2 == 0);
        default: pg_valid_i = 1'($urandom);
      endcase
      case (rmode)
        0:       m_axis.tready = 1'b1;
        1:       m_axis.tready = (c >= 12);
        default: m_axis.tready = 1'($urandom);
      endcase
      pg_data_i = directed ? (256'(8'hA0) + 256'(c)) : rand_pg();
      start_i   = inj_start && (c == 2);
      dest_i    = DSTW'($urandom);
      cycle();
      if (frame_done_o) begin
        done = 1'b1;
        dcyc = c;
      end
    end
    start_i    = 1'b0;
    pg_valid_i = 1'b0;
    m_axis.tready = 1'b1;
    chk("frame_completes", 260'(done), 260'(1'b1));
    if (directed) chk("frame_done_cycle", 260'(dcyc), 260'(4));
    // groups offered while idle must be left alone
    pg_valid_i = 1'b1;
    pg_data_i  = rand_pg();
    repeat (3) cycle();
    pg_valid_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] x1, x3;
    rst = 1'b1;
    start_i = 1'b0; dest_i = '0; pg_data_i = '0; pg_valid_i = 1'b0;
    m_axis.tready = 1'b1;
    d1_start = 1'b0; d1_dest = '0; d1_data = '0; d1_valid = 1'b0;
    s_axis1.tready = 1'b1;
    repeat (2) cycle();
    chk("rst_tvalid", 260'(m_axis.tvalid), 260'(1'b0));
    chk("rst_tdata", 260'(m_axis.tdata), 260'(0));
    chk("rst_busy_ready_done", 260'({busy_o, pg_ready_o, frame_done_o}), 260'(3'b000));
    chk("rst_tkeep", 260'(m_axis.tkeep), 260'({32{1'b1}}));
    rst = 1'b0;
    cycle();

    // directed frame, back-to-back; backpressure; start during stream; mixed
    run_frame(0, 0, 1'b0, 1'b1);
    run_frame(0, 1, 1'b0, 1'b0);
    run_frame(0, 0, 1'b1, 1'b0);
    run_frame(1, 2, 1'b0, 1'b0);
    run_frame(2, 2, 1'b1, 1'b0);   // fifth frame: id wraps to 0
    for (int f = 0; f < 6; f++) run_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 1'b0);

    // reset in the middle of a frame after two groups are taken
    start_i = 1'b1; dest_i = 1'b1; cycle(); start_i = 1'b0;
    pg_valid_i = 1'b1; m_axis.tready = 1'b0;
    pg_data_i = rand_pg(); cycle();
    pg_data_i = rand_pg(); cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid_tlast", 260'({m_axis.tvalid, m_axis.tlast}), 260'(2'b00));
    chk("arst_tdata", 260'(m_axis.tdata), 260'(0));
    chk("arst_tid_tdest", 260'({m_axis.tid, m_axis.tdest}), 260'(0));
    chk("arst_busy_ready", 260'({busy_o, pg_ready_o, frame_done_o}), 260'(0));
    pg_valid_i = 1'b0; m_axis.tready = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    run_frame(0, 0, 1'b0, 1'b0);   // starts again at id 0

    // single-group frames on the second instance
    d1_valid = 1'b1; d1_data = rand_pg(); cycle();
    chk("p1_idle_ready", 260'({d1_ready, d1_busy, s_axis1.tvalid}), 260'(3'b000));
    d1_start = 1'b1; d1_dest = 1'b1; d1_valid = 1'b0; cycle();
    d1_start = 1'b0;
    chk("p1_stream_ready", 260'({d1_ready, d1_busy, s_axis1.tvalid}), 260'(3'b110));
    x1 = rand_pg();
    d1_valid = 1'b1; d1_data = x1; s_axis1.tready = 1'b0; cycle();
    chk("p1_beat_data", 260'(s_axis1.tdata), 260'(x1));
    chk("p1_beat_flags", 260'({s_axis1.tvalid, s_axis1.tlast, s_axis1.tid, s_axis1.tdest}), 260'(5'b11001));
    chk("p1_drain_ready", 260'({d1_ready, d1_busy}), 260'(2'b01));
    d1_data = rand_pg(); cycle();
    chk("p1_hold_data", 260'(s_axis1.tdata), 260'(x1));
    chk("p1_hold_ready", 260'({d1_ready, s_axis1.tvalid}), 260'(2'b01));
    s_axis1.tready = 1'b1; d1_valid = 1'b0; cycle();
    chk("p1_done", 260'({d1_done, d1_busy, s_axis1.tvalid}), 260'(3'b100));
    cycle();
    chk("p1_done_pulse", 260'(d1_done), 260'(1'b0));
    d1_start = 1'b1; d1_dest = 1'b0; cycle(); d1_start = 1'b0;
    x3 = rand_pg();
    d1_valid = 1'b1; d1_data = x3; cycle();
    d1_valid = 1'b0;
    chk("p1_f2_beat", 260'({s_axis1.tdata, s_axis1.tlast, s_axis1.tid}), 260'({x3, 1'b1, 2'd1}));
    cycle();
    chk("p1_f2_done", 260'(d1_done), 260'(1'b1));

    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1);
  end

endmodule
